// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: port identifiers and default widths.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 30;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Grant selection for the fetch and data ports. With MEM_ARBITER_RR_EN defined, conflicts
// alternate between the ports; otherwise the data port has fixed priority.
module mem_arbiter_pick
  import mem_arbiter_pkg::*;
(
  input  logic  i_if_req,
  input  logic  i_d_req,
  input  logic  i_mem_ready,
  input  port_e i_last,
  output logic  o_if_gnt,
  output logic  o_d_gnt,
  output port_e o_next_last
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    o_if_gnt = 1'b0;
    o_d_gnt  = 1'b0;
    if (i_mem_ready) begin
      if (i_if_req && i_d_req) begin
`ifdef MEM_ARBITER_RR_EN
        o_d_gnt  = (i_last == PORT_IF);
        o_if_gnt = (i_last == PORT_D);
`else
        o_d_gnt  = 1'b1;
`endif
      end else begin
        o_if_gnt = i_if_req;
        o_d_gnt  = i_d_req;
      end
    end
  end

  // The last-granted port only moves when something is actually granted.
  always_comb begin
    o_next_last = i_last;
    if (o_d_gnt)       o_next_last = PORT_D;
    else if (o_if_gnt) o_next_last = PORT_IF;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto one single-cycle-latency memory port.
// Optional MEM_ARBITER_RR_EN selects round-robin conflict resolution instead of data priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                i_clk,
  input  logic                i_rst,

  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,

  input  logic                i_d_req,
  input  logic                i_d_is_store,
  input  logic [ADDR_W-1:0]   i_d_addr,
  input  logic [DATA_W-1:0]   i_d_store_data,
  input  logic [DATA_W/8-1:0] i_d_store_mask,
  output logic                o_d_gnt,
  output logic                o_d_rvalid,
  output logic [DATA_W-1:0]   o_d_rdata,

  output logic                o_mem_req,
  output logic                o_mem_is_store,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_store_data,
  output logic [DATA_W/8-1:0] o_mem_store_mask,
  input  logic                i_mem_ready,
  input  logic [DATA_W-1:0]   i_mem_load_data
);

  logic  r_resp_valid;
  port_e r_resp_owner;
  port_e r_last;

  logic  w_ready;
  logic  w_if_gnt;
  logic  w_d_gnt;
  logic  w_read_gnt;
  port_e w_next_last;

  // Holding off ready during reset keeps grants and the memory request low without extra gating.
  assign w_ready = i_mem_ready & ~i_rst;

  mem_arbiter_pick u_pick (
    .i_if_req    (i_if_req),
    .i_d_req     (i_d_req),
    .i_mem_ready (w_ready),
    .i_last      (r_last),
    .o_if_gnt    (w_if_gnt),
    .o_d_gnt     (w_d_gnt),
    .o_next_last (w_next_last)
  );

  assign o_if_gnt         = w_if_gnt;
  assign o_d_gnt          = w_d_gnt;
  assign o_mem_req        = w_if_gnt | w_d_gnt;
  assign o_mem_is_store   = w_d_gnt & i_d_is_store;
  assign o_mem_addr       = w_d_gnt ? i_d_addr : i_if_addr;
  assign o_mem_store_data = w_d_gnt ? i_d_store_data : '0;
  assign o_mem_store_mask = w_d_gnt ? i_d_store_mask : '0;

  assign w_read_gnt = w_if_gnt | (w_d_gnt & ~i_d_is_store);

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (i_rst) begin
      r_resp_valid <= 1'b0;
      r_resp_owner <= PORT_IF;
      r_last       <= PORT_IF;
    end else begin
      r_resp_valid <= w_read_gnt;
      if (w_read_gnt) r_resp_owner <= w_d_gnt ? PORT_D : PORT_IF;
      r_last       <= w_next_last;
    end
  end

  // A response still in flight when reset rises is suppressed in that same cycle.
  assign o_if_rvalid = r_resp_valid & ~i_rst & (r_resp_owner == PORT_IF);
  assign o_d_rvalid  = r_resp_valid & ~i_rst & (r_resp_owner == PORT_D);
  assign o_if_rdata  = i_mem_load_data;
  assign o_d_rdata   = i_mem_load_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vectors, corner sequences and a randomized
// run against a transaction-level model. Honors MEM_ARBITER_RR_EN for expected arbitration.
module tb_mem_arbiter;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;

`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              i_clk;
  logic              i_rst;
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_gnt, o_if_rvalid;
  logic [DATA_W-1:0] o_if_rdata;
  logic              i_d_req, i_d_is_store;
  logic [ADDR_W-1:0] i_d_addr;
  logic [DATA_W-1:0] i_d_store_data;
  logic [MASK_W-1:0] i_d_store_mask;
  logic              o_d_gnt, o_d_rvalid;
  logic [DATA_W-1:0] o_d_rdata;
  logic              o_mem_req, o_mem_is_store;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_store_data;
  logic [MASK_W-1:0] o_mem_store_mask;
  logic              i_mem_ready;
  logic [DATA_W-1:0] i_mem_load_data;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_is_store(i_d_is_store), .i_d_addr(i_d_addr),
    .i_d_store_data(i_d_store_data), .i_d_store_mask(i_d_store_mask),
    .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
    .o_mem_req(o_mem_req), .o_mem_is_store(o_mem_is_store), .o_mem_addr(o_mem_addr),
    .o_mem_store_data(o_mem_store_data), .o_mem_store_mask(o_mem_store_mask),
    .i_mem_ready(i_mem_ready), .i_mem_load_data(i_mem_load_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory seen by the DUT (environment) and the model's own copy.
  logic [DATA_W-1:0] env_mem [256];
  logic [DATA_W-1:0] ref_mem [256];

  // Outputs captured mid-cycle by cycle().
  logic              s_if_gnt, s_d_gnt, s_mem_req, s_if_rv, s_d_rv, s_is_store;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_sdata, s_if_rdata, s_d_rdata;
  logic [MASK_W-1:0] s_mask;

  // One clock: sample outputs on the falling edge, act as the memory, then present
  // read data during the following cycle.
  task automatic cycle();
    logic              rd_pend;
    logic [DATA_W-1:0] rd_data;
    @(negedge i_clk);
    s_if_gnt = o_if_gnt;  s_d_gnt = o_d_gnt;  s_mem_req = o_mem_req;
    s_if_rv = o_if_rvalid; s_d_rv = o_d_rvalid; s_is_store = o_mem_is_store;
    s_addr = o_mem_addr; s_sdata = o_mem_store_data; s_mask = o_mem_store_mask;
    s_if_rdata = o_if_rdata; s_d_rdata = o_d_rdata;
    rd_pend = 1'b0;
    rd_data = '0;
    if (o_mem_req && i_mem_ready) begin
      if (o_mem_is_store) begin
        for (int b = 0; b < MASK_W; b++)
          if (o_mem_store_mask[b]) env_mem[o_mem_addr[7:0]][8*b +: 8] = o_mem_store_data[8*b +: 8];
      end else begin
        rd_pend = 1'b1;
        rd_data = env_mem[o_mem_addr[7:0]];
      end
    end
    @(posedge i_clk);
    #1;
    i_mem_load_data = rd_pend ? rd_data : $urandom();
  endtask

  task automatic clear_inputs();
    i_if_req = 1'b0; i_if_addr = '0;
    i_d_req = 1'b0; i_d_is_store = 1'b0; i_d_addr = '0;
    i_d_store_data = '0; i_d_store_mask = '0;
    i_mem_ready = 1'b1;
  endtask

  typedef struct {
    logic rst, if_req, d_req, ready;
    logic e_if_gnt, e_d_gnt, e_if_rv, e_d_rv;
    logic [DATA_W-1:0] e_rdata;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic ifr, input logic dr, input logic rdy,
                              input logic eif, input logic ed, input logic eifrv, input logic edrv,
                              input logic [DATA_W-1:0] rd);
    vec_t v;
    v.rst = rst; v.if_req = ifr; v.d_req = dr; v.ready = rdy;
    v.e_if_gnt = eif; v.e_d_gnt = ed; v.e_if_rv = eifrv; v.e_d_rv = edrv; v.e_rdata = rd;
    return v;
  endfunction

  vec_t vecs [15];

  // Transaction-level model state.
  bit                m_last_d;
  bit                m_pend_v, m_pend_d;
  logic [DATA_W-1:0] m_pend_data;

  initial begin
    logic [DATA_W-1:0] rd_if, rd_d;
    bit hold_if, hold_d;

    for (int a = 0; a < 256; a++) env_mem[a] = 32'hA5A5_0000 | DATA_W'(a);
    clear_inputs();
    i_mem_load_data = '0;

    // Reset with both ports requesting: nothing may be granted or reported.
    i_rst = 1'b1; i_if_req = 1'b1; i_d_req = 1'b1;
    cycle();
    cycle();
    check("rst if_gnt", s_if_gnt, 0);
    check("rst d_gnt", s_d_gnt, 0);
    check("rst mem_req", s_mem_req, 0);
    check("rst if_rvalid", s_if_rv, 0);
    check("rst d_rvalid", s_d_rv, 0);

    // Single fetch read.
    i_rst = 1'b0; clear_inputs();
    i_if_req = 1'b1; i_if_addr = 30'h10;
    cycle();
    check("fetch if_gnt", s_if_gnt, 1);
    check("fetch d_gnt", s_d_gnt, 0);
    check("fetch mem_req", s_mem_req, 1);
    check("fetch mem_addr", s_addr, 30'h10);
    check("fetch is_store", s_is_store, 0);
    check("fetch mask", s_mask, 0);
    clear_inputs();
    cycle();
    check("fetch if_rvalid", s_if_rv, 1);
    check("fetch d_rvalid", s_d_rv, 0);
    check("fetch if_rdata", s_if_rdata, 32'hA5A5_0010);

    // Conflict, stall and single-requester vectors (fetch 0x20, data load 0x30).
    rd_if = 32'hA5A5_0020;
    rd_d  = 32'hA5A5_0030;
    vecs[0]  = mk(1, 1, 1, 1,  0, 0, 0, 0, '0);
    vecs[1]  = mk(0, 1, 1, 1,  0, 1, 0, 0, '0);
    vecs[2]  = mk(0, 1, 1, 1,  RR, !RR, 0, 1, rd_d);
    vecs[3]  = mk(0, 1, 1, 1,  0, 1, RR, !RR, RR ? rd_if : rd_d);
    vecs[4]  = mk(0, 0, 0, 1,  0, 0, 0, 1, rd_d);
    vecs[5]  = mk(0, 1, 1, 0,  0, 0, 0, 0, '0);
    vecs[6]  = mk(0, 1, 1, 0,  0, 0, 0, 0, '0);
    vecs[7]  = mk(0, 1, 1, 0,  0, 0, 0, 0, '0);
    vecs[8]  = mk(0, 1, 1, 0,  0, 0, 0, 0, '0);
    vecs[9]  = mk(0, 1, 1, 1,  RR, !RR, 0, 0, '0);
    vecs[10] = mk(0, 0, 0, 1,  0, 0, RR, !RR, RR ? rd_if : rd_d);
    vecs[11] = mk(0, 0, 1, 1,  0, 1, 0, 0, '0);
    vecs[12] = mk(0, 1, 0, 1,  1, 0, 0, 1, rd_d);
    vecs[13] = mk(0, 1, 0, 1,  1, 0, 1, 0, rd_if);
    vecs[14] = mk(0, 0, 0, 1,  0, 0, 1, 0, rd_if);

    for (int i = 0; i < 15; i++) begin
      clear_inputs();
      i_rst = vecs[i].rst;
      i_if_req = vecs[i].if_req; i_if_addr = 30'h20;
      i_d_req = vecs[i].d_req;   i_d_addr = 30'h30;
      i_mem_ready = vecs[i].ready;
      cycle();
      check($sformatf("vec%0d if_gnt", i), s_if_gnt, vecs[i].e_if_gnt);
      check($sformatf("vec%0d d_gnt", i), s_d_gnt, vecs[i].e_d_gnt);
      check($sformatf("vec%0d mem_req", i), s_mem_req, vecs[i].e_if_gnt | vecs[i].e_d_gnt);
      check($sformatf("vec%0d if_rvalid", i), s_if_rv, vecs[i].e_if_rv);
      check($sformatf("vec%0d d_rvalid", i), s_d_rv, vecs[i].e_d_rv);
      if (vecs[i].e_if_rv) check($sformatf("vec%0d if_rdata", i), s_if_rdata, vecs[i].e_rdata);
      if (vecs[i].e_d_rv)  check($sformatf("vec%0d d_rdata", i), s_d_rdata, vecs[i].e_rdata);
    end

    // Masked store of the low halfword, then read it back.
    clear_inputs(); i_rst = 1'b0;
    i_d_req = 1'b1; i_d_is_store = 1'b1; i_d_addr = 30'h8;
    i_d_store_data = 32'hDEAD_BEEF; i_d_store_mask = 4'b0011;
    cycle();
    check("store d_gnt", s_d_gnt, 1);
    check("store is_store", s_is_store, 1);
    check("store mask", s_mask, 4'b0011);
    check("store data", s_sdata, 32'hDEAD_BEEF);
    check("store addr", s_addr, 30'h8);
    clear_inputs();
    cycle();
    check("store no d_rvalid", s_d_rv, 0);
    check("store no if_rvalid", s_if_rv, 0);
    i_d_req = 1'b1; i_d_addr = 30'h8;
    cycle();
    check("reload d_gnt", s_d_gnt, 1);
    check("reload is_store", s_is_store, 0);
    clear_inputs();
    cycle();
    check("reload d_rvalid", s_d_rv, 1);
    check("reload d_rdata", s_d_rdata, 32'hA5A5_BEEF);

    // Reset right after a granted load drops its response.
    i_d_req = 1'b1; i_d_addr = 30'h30;
    cycle();
    check("pre-rst d_gnt", s_d_gnt, 1);
    i_rst = 1'b1;
    cycle();
    check("mid-rst d_rvalid", s_d_rv, 0);
    check("mid-rst if_rvalid", s_if_rv, 0);
    check("mid-rst d_gnt", s_d_gnt, 0);
    check("mid-rst mem_req", s_mem_req, 0);
    i_rst = 1'b0; clear_inputs();
    cycle();
    check("post-rst d_rvalid", s_d_rv, 0);
    check("post-rst if_rvalid", s_if_rv, 0);
    check("post-rst mem_req", s_mem_req, 0);

    // Randomized traffic against the transaction-level model.
    for (int a = 0; a < 256; a++) ref_mem[a] = env_mem[a];
    m_last_d = 1'b0; m_pend_v = 1'b0; m_pend_d = 1'b0; m_pend_data = '0;
    hold_if = 1'b0; hold_d = 1'b0;
    for (int n = 0; n < 400; n++) begin
      bit e_if_rv, e_d_rv, w_if, w_d;
      logic [DATA_W-1:0] e_rdata;
      i_rst = ($urandom_range(0, 39) == 0);
      if (!hold_if) begin
        i_if_req  = 1'($urandom_range(0, 1));
        i_if_addr = ADDR_W'($urandom_range(0, 255));
      end
      if (!hold_d) begin
        i_d_req        = 1'($urandom_range(0, 1));
        i_d_is_store   = 1'($urandom_range(0, 1));
        i_d_addr       = ADDR_W'($urandom_range(0, 255));
        i_d_store_data = $urandom();
        i_d_store_mask = MASK_W'($urandom_range(0, 15));
      end
      i_mem_ready = ($urandom_range(0, 3) != 0);

      e_if_rv = !i_rst && m_pend_v && !m_pend_d;
      e_d_rv  = !i_rst && m_pend_v && m_pend_d;
      e_rdata = m_pend_data;
      w_if = 1'b0; w_d = 1'b0;
      if (!i_rst && i_mem_ready) begin
        if (i_if_req && i_d_req) begin
          w_d  = RR ? !m_last_d : 1'b1;
          w_if = !w_d;
        end else begin
          w_if = i_if_req;
          w_d  = i_d_req;
        end
      end
      if (i_rst) begin
        m_pend_v = 1'b0;
        m_last_d = 1'b0;
      end else begin
        m_pend_v = 1'b0;
        if (w_if) begin
          m_last_d = 1'b0;
          m_pend_v = 1'b1; m_pend_d = 1'b0; m_pend_data = ref_mem[i_if_addr[7:0]];
        end
        if (w_d) begin
          m_last_d = 1'b1;
          if (i_d_is_store) begin
            for (int b = 0; b < MASK_W; b++)
              if (i_d_store_mask[b]) ref_mem[i_d_addr[7:0]][8*b +: 8] = i_d_store_data[8*b +: 8];
          end else begin
            m_pend_v = 1'b1; m_pend_d = 1'b1; m_pend_data = ref_mem[i_d_addr[7:0]];
          end
        end
      end

      cycle();
      check($sformatf("rnd%0d if_gnt", n), s_if_gnt, w_if);
      check($sformatf("rnd%0d d_gnt", n), s_d_gnt, w_d);
      check($sformatf("rnd%0d mem_req", n), s_mem_req, w_if | w_d);
      check($sformatf("rnd%0d if_rvalid", n), s_if_rv, e_if_rv);
      check($sformatf("rnd%0d d_rvalid", n), s_d_rv, e_d_rv);
      if (e_if_rv) check($sformatf("rnd%0d if_rdata", n), s_if_rdata, e_rdata);
      if (e_d_rv)  check($sformatf("rnd%0d d_rdata", n), s_d_rdata, e_rdata);
      if (w_if) begin
        check($sformatf("rnd%0d if addr", n), s_addr, i_if_addr);
        check($sformatf("rnd%0d if is_store", n), s_is_store, 0);
        check($sformatf("rnd%0d if mask", n), s_mask, 0);
      end
      if (w_d) begin
        check($sformatf("rnd%0d d addr", n), s_addr, i_d_addr);
        check($sformatf("rnd%0d d is_store", n), s_is_store, i_d_is_store);
        if (i_d_is_store) begin
          check($sformatf("rnd%0d d sdata", n), s_sdata, i_d_store_data);
          check($sformatf("rnd%0d d mask", n), s_mask, i_d_store_mask);
        end
      end
      hold_if = i_if_req && !w_if && !i_rst;
      hold_d  = i_d_req && !w_d && !i_rst;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
